// File: rtl/fpnew_pkg.sv
// Format table and helpers shared by the FP datapath.
// Also holds the special-value kinds used by fpnew_special_result.
package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 5;
    localparam int unsigned FP_FORMAT_BITS = 3;

    typedef enum logic [FP_FORMAT_BITS-1:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        int unsigned exp_bits;
        int unsigned man_bits;
    } fp_encoding_t;

    localparam fp_encoding_t [0:NUM_FP_FORMATS-1] FP_ENCODINGS = '{
        '{8, 23}, '{11, 52}, '{5, 10}, '{5, 2}, '{8, 7}
    };

    typedef enum logic [1:0] {
        QNAN    = 2'd0,
        INF     = 2'd1,
        ZERO    = 2'd2,
        MAXNORM = 2'd3
    } special_kind_e;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        return FP_ENCODINGS[fmt].exp_bits;
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        return FP_ENCODINGS[fmt].man_bits;
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    function automatic int unsigned max_fp_width();
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < NUM_FP_FORMATS; i++) begin
            if (fp_width(fp_format_e'(i[FP_FORMAT_BITS-1:0])) > w) begin
                w = fp_width(fp_format_e'(i[FP_FORMAT_BITS-1:0]));
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fpnew_pipe_stage.sv
// One valid/ready register slice for an arbitrary payload type.
// Flush clears the valid bit and wins over any load or drain.
module fpnew_pipe_stage #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic valid_d, valid_q;
    T     data_d, data_q;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/fpnew_special_result.sv
// Run-time multi-format generator of canonical special FP values,
// NaN-boxed to Width and carried through a flushable valid/ready pipeline.
module fpnew_special_result import fpnew_pkg::*; #(
    parameter int unsigned Width       = 64,
    parameter int unsigned NumPipeRegs = 1,
    parameter int unsigned TagWidth    = 4,
    parameter bit          NanBox      = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  fp_format_e          fmt_i,
    input  special_kind_e       kind_i,
    input  logic                sign_i,
    input  logic [TagWidth-1:0] tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    result_o,
    output logic                fmt_err_o,
    output logic [TagWidth-1:0] tag_o,
    output logic                busy_o
);

    if (Width < max_fp_width()) begin : g_width_check
        $error("Width must cover the widest FP format");
    end
    if (NumPipeRegs > 4) begin : g_depth_check
        $error("NumPipeRegs must be 0..4");
    end

    typedef struct packed {
        logic [Width-1:0]    result;
        logic                fmt_err;
        logic [TagWidth-1:0] tag;
    } payload_t;

    localparam logic [Width-1:0] One = Width'(1);

    int unsigned      e, m;
    logic             fmt_err;
    logic [Width-1:0] exp_ones, sign_bit, man_ones, box, enc;
    payload_t         enc_payload;

    // Field masks are built from shifts so one datapath serves every format;
    // a shift by the full width yields zero, which makes FP64 box to nothing.
    always_comb begin
        fmt_err = fmt_i >= FP_FORMAT_BITS'(NUM_FP_FORMATS);
        e = 0;
        m = 1;
        if (!fmt_err) begin
            e = exp_bits(fmt_i);
            m = man_bits(fmt_i);
        end
        exp_ones = ((One << e) - One) << m;
        sign_bit = sign_i ? (One << (e + m)) : '0;
        man_ones = (One << m) - One;
        box      = NanBox ? ~((One << (e + m + 1)) - One) : '0;
        enc      = '0;
        case (kind_i)
            QNAN:    enc = exp_ones | (One << (m - 1));
            INF:     enc = sign_bit | exp_ones;
            ZERO:    enc = sign_bit;
            MAXNORM: enc = sign_bit | (exp_ones - (One << m)) | man_ones;
        endcase
        enc_payload.result  = fmt_err ? '0 : (enc | box);
        enc_payload.fmt_err = fmt_err;
        enc_payload.tag     = tag_i;
    end

    payload_t pl  [NumPipeRegs+1];
    logic     vld [NumPipeRegs+1];
    logic     rdy [NumPipeRegs+1];

    assign pl[0]            = enc_payload;
    assign vld[0]           = in_valid_i;
    assign rdy[NumPipeRegs] = out_ready_i;

    for (genvar k = 0; k < NumPipeRegs; k++) begin : g_stage
        fpnew_pipe_stage #(
            .T (payload_t)
        ) u_stage (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i),
            .in_valid_i  (vld[k]),
            .in_ready_o  (rdy[k]),
            .in_data_i   (pl[k]),
            .out_valid_o (vld[k+1]),
            .out_ready_i (rdy[k+1]),
            .out_data_o  (pl[k+1])
        );
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = vld[NumPipeRegs];
    assign result_o    = pl[NumPipeRegs].result;
    assign fmt_err_o   = pl[NumPipeRegs].fmt_err;
    assign tag_o       = pl[NumPipeRegs].tag;

    always_comb begin
        busy_o = 1'b0;
        for (int unsigned k = 1; k <= NumPipeRegs; k++) begin
            busy_o = busy_o | vld[k];
        end
    end

endmodule

// File: tb/tb_fpnew_special_result.sv
// Scoreboard bench for fpnew_special_result across three pipeline configurations.
module tb_fpnew_special_result;
    import fpnew_pkg::*;

    localparam int unsigned NREG [3] = '{1, 3, 2};
    localparam bit          NB   [3] = '{1'b1, 1'b1, 1'b0};

    typedef struct {
        logic [63:0] res;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush     [3];
    logic          in_valid  [3];
    logic          in_ready  [3];
    fp_format_e    fmt       [3];
    special_kind_e kind      [3];
    logic          sign      [3];
    logic [3:0]    tag       [3];
    logic          out_valid [3];
    logic          out_ready [3];
    logic [63:0]   res       [3];
    logic          ferr      [3];
    logic [3:0]    tag_out   [3];
    logic          busy      [3];

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    bit   rand_rdy [3];
    exp_t mem [3][256];
    int   wr [3];
    int   rd [3];

    always #5 clk = ~clk;

    fpnew_special_result #(.Width(64), .NumPipeRegs(1), .TagWidth(4), .NanBox(1'b1)) u_d0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
        .in_ready_o(in_ready[0]), .fmt_i(fmt[0]), .kind_i(kind[0]), .sign_i(sign[0]),
        .tag_i(tag[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .result_o(res[0]), .fmt_err_o(ferr[0]), .tag_o(tag_out[0]), .busy_o(busy[0]));

    fpnew_special_result #(.Width(64), .NumPipeRegs(3), .TagWidth(4), .NanBox(1'b1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
        .in_ready_o(in_ready[1]), .fmt_i(fmt[1]), .kind_i(kind[1]), .sign_i(sign[1]),
        .tag_i(tag[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .result_o(res[1]), .fmt_err_o(ferr[1]), .tag_o(tag_out[1]), .busy_o(busy[1]));

    fpnew_special_result #(.Width(64), .NumPipeRegs(2), .TagWidth(4), .NanBox(1'b0)) u_d2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[2]), .in_valid_i(in_valid[2]),
        .in_ready_o(in_ready[2]), .fmt_i(fmt[2]), .kind_i(kind[2]), .sign_i(sign[2]),
        .tag_i(tag[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
        .result_o(res[2]), .fmt_err_o(ferr[2]), .tag_o(tag_out[2]), .busy_o(busy[2]));

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: value = sign*2^(E+M) + exponent*2^M + mantissa, then box above F bits.
    function automatic logic [64:0] model(int f, int k, bit s, bit nb);
        longint unsigned one = 1;
        longint unsigned r, expo, mant;
        int ebits, mbits, fw;
        case (f)
            0: begin ebits = 8;  mbits = 23; end
            1: begin ebits = 11; mbits = 52; end
            2: begin ebits = 5;  mbits = 10; end
            3: begin ebits = 5;  mbits = 2;  end
            4: begin ebits = 8;  mbits = 7;  end
            default: return {1'b1, 64'd0};
        endcase
        fw = 1 + ebits + mbits;
        expo = (one << ebits) - 1;
        mant = 0;
        case (k)
            0: begin s = 1'b0; mant = one << (mbits - 1); end
            1: mant = 0;
            2: begin expo = 0; mant = 0; end
            default: begin expo = expo - 1; mant = (one << mbits) - 1; end
        endcase
        r = (s ? (one << (ebits + mbits)) : 0) + expo * (one << mbits) + mant;
        if (nb && fw < 64) r = r | ~((one << fw) - 1);
        return {1'b0, r};
    endfunction

    // Monitor: check status against model occupancy, check head of queue, then advance.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                int occ;
                logic [64:0] mv;
                occ = wr[i] - rd[i];
                chk($sformatf("in_ready%0d", i), 64'(in_ready[i]),
                    64'(!(occ == int'(NREG[i]) && !out_ready[i])));
                chk($sformatf("busy%0d", i), 64'(busy[i]), 64'(occ != 0));
                if (out_valid[i]) begin
                    if (occ == 0) begin
                        chk($sformatf("unexpected_out%0d", i), 64'(out_valid[i]), 64'd0);
                    end else begin
                        chk($sformatf("result%0d", i), res[i], mem[i][rd[i] & 255].res);
                        chk($sformatf("fmt_err%0d", i), 64'(ferr[i]), 64'(mem[i][rd[i] & 255].err));
                        chk($sformatf("tag%0d", i), 64'(tag_out[i]), 64'(mem[i][rd[i] & 255].tag));
                    end
                end
                if (rst || flush[i]) begin
                    rd[i] = wr[i];
                end else begin
                    if (out_valid[i] && out_ready[i] && occ > 0) rd[i]++;
                    if (in_valid[i] && in_ready[i]) begin
                        mv = model(int'(fmt[i]), int'(kind[i]), sign[i], NB[i]);
                        mem[i][wr[i] & 255].res = mv[63:0];
                        mem[i][wr[i] & 255].err = mv[64];
                        mem[i][wr[i] & 255].tag = tag[i];
                        wr[i]++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (rand_rdy[i]) out_ready[i] = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(int i, int f, int k, bit s, int t);
        bit hs;
        in_valid[i] = 1'b1;
        fmt[i]  = fp_format_e'(f[2:0]);
        kind[i] = special_kind_e'(k[1:0]);
        sign[i] = s;
        tag[i]  = t[3:0];
        hs = 1'b0;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk);
            hs = in_ready[i];
            @(posedge clk);
            #1;
        end
        if (!hs) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic dir(int i, int f, int k, bit s, int t, logic [63:0] er, bit ee);
        out_ready[i] = 1'b1;
        send(i, f, k, s, t);
        in_valid[i] = 1'b0;
        repeat (NREG[i] - 1) @(posedge clk);
        @(negedge clk);
        chk("dir_valid", 64'(out_valid[i]), 64'd1);
        chk("dir_result", res[i], er);
        chk("dir_fmt_err", 64'(ferr[i]), 64'(ee));
        chk("dir_tag", 64'(tag_out[i]), 64'(t[3:0]));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int i);
        rand_rdy[i]  = 1'b0;
        in_valid[i]  = 1'b0;
        @(posedge clk);
        #1;
        out_ready[i] = 1'b1;
        for (int c = 0; c < 100 && wr[i] != rd[i]; c++) @(posedge clk);
        #1;
        if (wr[i] != rd[i]) chk("drain_timeout", 64'(wr[i] - rd[i]), 64'd0);
    endtask

    task automatic chk_reset(int i);
        chk("rst_valid", 64'(out_valid[i]), 64'd0);
        chk("rst_in_ready", 64'(in_ready[i]), 64'd1);
        chk("rst_busy", 64'(busy[i]), 64'd0);
        chk("rst_result", res[i], 64'd0);
        chk("rst_tag", 64'(tag_out[i]), 64'd0);
        chk("rst_fmt_err", 64'(ferr[i]), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
            fmt[i] = FP32; kind[i] = QNAN; sign[i] = 1'b0; tag[i] = 4'd0;
            rand_rdy[i] = 1'b0; wr[i] = 0; rd[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset(i);
        @(posedge clk);
        #1;

        dir(0, 1, 0, 1'b0, 1, 64'h7FF8000000000000, 1'b0);
        dir(0, 0, 0, 1'b1, 2, 64'hFFFFFFFF7FC00000, 1'b0);
        dir(0, 3, 0, 1'b0, 3, 64'hFFFFFFFFFFFFFF7E, 1'b0);
        dir(0, 4, 0, 1'b0, 4, 64'hFFFFFFFFFFFF7FC0, 1'b0);
        dir(0, 1, 1, 1'b1, 5, 64'hFFF0000000000000, 1'b0);
        dir(0, 0, 3, 1'b1, 6, 64'hFFFFFFFFFF7FFFFF, 1'b0);
        dir(2, 2, 2, 1'b1, 7, 64'h0000000000008000, 1'b0);
        dir(1, 6, 1, 1'b0, 5, 64'h0, 1'b1);

        rand_rdy[1] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            send(1, $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)), t);
        end
        drain(1);

        for (int i = 0; i < 3; i++) begin
            rand_rdy[i] = 1'b1;
            for (int n = 0; n < 40; n++) begin
                in_valid[i] = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(i, $urandom_range(0, 7), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), $urandom_range(0, 15));
            end
            drain(i);
        end

        out_ready[2] = 1'b0;
        send(2, 1, 1, 1'b0, 9);
        send(2, 0, 3, 1'b1, 10);
        fmt[2] = FP16; kind[2] = INF; tag[2] = 4'd11;
        out_ready[2] = 1'b1;
        flush[2] = 1'b1;
        @(posedge clk);
        #1;
        flush[2] = 1'b0;
        in_valid[2] = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy[2]), 64'd0);
        chk("flush_valid", 64'(out_valid[2]), 64'd0);
        repeat (6) @(posedge clk);
        #1;

        out_ready[1] = 1'b0;
        send(1, 1, 0, 1'b0, 12);
        send(1, 2, 1, 1'b1, 13);
        send(1, 3, 3, 1'b0, 14);
        in_valid[1] = 1'b0;
        @(negedge clk);
        chk("full_valid", 64'(out_valid[1]), 64'd1);
        @(posedge clk);
        #1;
        out_ready[1] = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset(i);
        repeat (6) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
